// File: rtl/lr_output_collector.sv
// Realigns the four skewed leaky-ReLU column streams into 64-bit rows and
// writes them to the unified buffer at incrementing addresses.
module lr_output_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [ADDR_W-1:0] row_count_in,
    input  logic              lr_valid_1_in,
    input  logic              lr_valid_2_in,
    input  logic              lr_valid_3_in,
    input  logic              lr_valid_4_in,
    input  logic [15:0]       lr_data_1_in,
    input  logic [15:0]       lr_data_2_in,
    input  logic [15:0]       lr_data_3_in,
    input  logic [15:0]       lr_data_4_in,
    output logic              ub_wr_en_out,
    output logic [ADDR_W-1:0] ub_wr_addr_out,
    output logic [63:0]       ub_wr_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [1:0]        err_out
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_addr, r_remaining;
    logic [1:0]        r_err;

    logic [3:0]  w_valid, w_empty, w_full, w_push, w_ovf, w_stray;
    logic [15:0] w_data [4];
    logic [15:0] w_head [4];
    logic        w_collect, w_pop, w_start_ok;

    assign w_valid   = {lr_valid_4_in, lr_valid_3_in, lr_valid_2_in, lr_valid_1_in};
    assign w_data[0] = lr_data_1_in;
    assign w_data[1] = lr_data_2_in;
    assign w_data[2] = lr_data_3_in;
    assign w_data[3] = lr_data_4_in;

    assign w_collect  = (r_state == S_COLLECT);
    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_pop      = w_collect && (w_empty == 4'b0000) && (r_remaining != '0);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            logic [15:0]      r_mem [FIFO_DEPTH];
            logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;

            // Extra pointer MSB distinguishes full from empty.
            assign w_empty[gi] = (r_wr_ptr == r_rd_ptr);
            assign w_full[gi]  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                                 (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
            assign w_push[gi]  = w_collect && w_valid[gi] && (!w_full[gi] || w_pop);
            assign w_ovf[gi]   = w_collect && w_valid[gi] && w_full[gi] && !w_pop;
            assign w_stray[gi] = !w_collect && w_valid[gi];
            assign w_head[gi]  = r_mem[r_rd_ptr[IDX_W-1:0]];

            // Leftovers are discarded while passing through DONE.
            always_ff @(posedge clk) begin
                if (rst || (r_state == S_DONE)) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push[gi]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    if (w_pop)      r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (w_push[gi]) r_mem[r_wr_ptr[IDX_W-1:0]] <= w_data[gi];
            end
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_next = (row_count_in == '0) ? S_DONE : S_COLLECT;
            S_COLLECT: if (w_pop && (r_remaining == ADDR_W'(1))) w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_err          <= '0;
            ub_wr_en_out   <= 1'b0;
            ub_wr_addr_out <= '0;
            ub_wr_data_out <= '0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            busy_out     <= (w_state_next != S_IDLE);
            done_out     <= (w_state_next == S_DONE);
            ub_wr_en_out <= w_pop;
            if (w_start_ok) begin
                r_addr      <= base_addr_in;
                r_remaining <= row_count_in;
            end else if (w_pop) begin
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - ADDR_W'(1);
            end
            if (w_pop) begin
                ub_wr_addr_out <= r_addr;
                ub_wr_data_out <= {w_head[3], w_head[2], w_head[1], w_head[0]};
            end
            r_err <= (w_start_ok ? 2'b00 : r_err) | {|w_stray, |w_ovf};
        end
    end

    assign err_out = r_err;
endmodule

// File: tb/tb_lr_output_collector.sv
// Directed bench for lr_output_collector: alignment, skew, zero rows,
// overflow, stray valid, address wrap and mid-job reset.
module tb_lr_output_collector;
    logic        clk = 1'b0;
    logic        rst, start;
    logic [7:0]  base_addr, row_count;
    logic [3:0]  vld;
    logic [15:0] dat [4];
    logic        ub_wr_en;
    logic [7:0]  ub_wr_addr;
    logic [63:0] ub_wr_data;
    logic        busy, done;
    logic [1:0]  err;

    lr_output_collector #(.FIFO_DEPTH(4), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr_in(base_addr), .row_count_in(row_count),
        .lr_valid_1_in(vld[0]), .lr_valid_2_in(vld[1]),
        .lr_valid_3_in(vld[2]), .lr_valid_4_in(vld[3]),
        .lr_data_1_in(dat[0]), .lr_data_2_in(dat[1]),
        .lr_data_3_in(dat[2]), .lr_data_4_in(dat[3]),
        .ub_wr_en_out(ub_wr_en), .ub_wr_addr_out(ub_wr_addr),
        .ub_wr_data_out(ub_wr_data), .busy_out(busy),
        .done_out(done), .err_out(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
        logic        dn;
        int          cyc;
    } wr_t;

    wr_t wr_q[$];
    int  cyc = 0;
    int  done_cnt = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (ub_wr_en) begin
            wr_q.push_back('{addr: ub_wr_addr, data: ub_wr_data, dn: done, cyc: cyc});
            $display("WR cyc=%0d addr=0x%02h data=0x%016h done=%0b", cyc, ub_wr_addr, ub_wr_data, done);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        vld = v; dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
        tick();
    endtask

    task automatic start_job(input logic [7:0] b, input logic [7:0] r);
        start = 1'b1; base_addr = b; row_count = r;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int snap);
        int n = 0;
        while (done_cnt == snap && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_done"}, done_cnt, snap + 1);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_wr(input string tag, input int i, input logic [7:0] a,
                            input logic [63:0] d, input logic dn);
        check($sformatf("%s_wr%0d_present", tag, i), wr_q.size() > i, 1'b1);
        if (wr_q.size() > i) begin
            check($sformatf("%s_wr%0d_addr", tag, i), wr_q[i].addr, a);
            check($sformatf("%s_wr%0d_data", tag, i), wr_q[i].data, d);
            check($sformatf("%s_wr%0d_done", tag, i), wr_q[i].dn, dn);
        end
    endtask

    initial begin
        int x, snap;
        rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0; vld = '0;
        for (int k = 0; k < 4; k++) dat[k] = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_wr_en", ub_wr_en, 0);
        check("rst_wr_addr", ub_wr_addr, 0);
        check("rst_wr_data", ub_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // Aligned rows
        wr_q.delete(); snap = done_cnt;
        start_job(8'h10, 8'd2);
        check("al_busy", busy, 1'b1);
        x = cyc;
        drive(4'hF, 16'd1, 16'd2, 16'd3, 16'd4);
        drive(4'hF, 16'd5, 16'd6, 16'd7, 16'd8);
        drive(4'h0, 0, 0, 0, 0);
        wait_done("al", snap);
        check("al_count", wr_q.size(), 2);
        check_wr("al", 0, 8'h10, 64'h0004_0003_0002_0001, 1'b0);
        check_wr("al", 1, 8'h11, 64'h0008_0007_0006_0005, 1'b1);
        if (wr_q.size() > 0) check("al_latency", wr_q[0].cyc, x + 2);

        // Skewed columns
        wr_q.delete(); snap = done_cnt;
        start_job(8'h00, 8'd3);
        drive(4'b0001, 16'hFFFF, 16'h0100, 16'h0100, 16'h0100);
        drive(4'b0011, 16'hFFFF, 16'h0100, 16'h0100, 16'h0100);
        drive(4'b0111, 16'hFFFF, 16'h0100, 16'h0100, 16'h0100);
        x = cyc;
        drive(4'b1111, 16'hFFFF, 16'h0100, 16'h0100, 16'h0100);
        drive(4'b1110, 16'hFFFF, 16'h0100, 16'h0100, 16'h0100);
        drive(4'b1100, 16'hFFFF, 16'h0100, 16'h0100, 16'h0100);
        drive(4'b1000, 16'hFFFF, 16'h0100, 16'h0100, 16'h0100);
        drive(4'b0000, 0, 0, 0, 0);
        wait_done("sk", snap);
        check("sk_count", wr_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_wr("sk", i, 8'(i), 64'h0100_0100_0100_FFFF, i == 2);
            if (wr_q.size() > i) check($sformatf("sk_wr%0d_cyc", i), wr_q[i].cyc, x + 2 + i);
        end
        check("sk_err", err, 2'b00);

        // Zero rows
        wr_q.delete(); snap = done_cnt;
        start_job(8'h40, 8'd0);
        check("zr_done_pulse", done, 1'b1);
        tick();
        check("zr_done_low", done, 1'b0);
        check("zr_idle", busy, 1'b0);
        check("zr_no_write", wr_q.size(), 0);
        check("zr_done_cnt", done_cnt, snap + 1);

        // Start while busy is ignored
        wr_q.delete(); snap = done_cnt;
        start_job(8'h20, 8'd2);
        drive(4'hF, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
        vld = 4'h0;
        start_job(8'h80, 8'd5);
        drive(4'hF, 16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04);
        drive(4'h0, 0, 0, 0, 0);
        wait_done("sb", snap);
        check("sb_count", wr_q.size(), 2);
        check_wr("sb", 0, 8'h20, 64'h0A04_0A03_0A02_0A01, 1'b0);
        check_wr("sb", 1, 8'h21, 64'h0B04_0B03_0B02_0B01, 1'b1);

        // Overflow on column 1
        wr_q.delete(); snap = done_cnt;
        start_job(8'h50, 8'd4);
        for (int i = 0; i < 5; i++) drive(4'b0001, 16'(i + 1), 0, 0, 0);
        drive(4'h0, 0, 0, 0, 0);
        check("ov_err", err, 2'b01);
        for (int i = 0; i < 4; i++) drive(4'b1110, 0, 16'(32'h20 + i), 16'(32'h30 + i), 16'(32'h40 + i));
        drive(4'h0, 0, 0, 0, 0);
        wait_done("ov", snap);
        check("ov_count", wr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_wr("ov", i, 8'(32'h50 + i),
                     {16'(32'h40 + i), 16'(32'h30 + i), 16'(32'h20 + i), 16'(i + 1)}, i == 3);

        // Stray valid in IDLE, then address wrap
        drive(4'b0010, 0, 16'h1234, 0, 0);
        drive(4'h0, 0, 0, 0, 0);
        check("st_err1", err[1], 1'b1);
        wr_q.delete(); snap = done_cnt;
        start_job(8'hFF, 8'd2);
        check("st_err_clear", err, 2'b00);
        drive(4'hF, 16'h1001, 16'h2001, 16'h3001, 16'h4001);
        drive(4'hF, 16'h1002, 16'h2002, 16'h3002, 16'h4002);
        drive(4'h0, 0, 0, 0, 0);
        wait_done("wr", snap);
        check_wr("wr", 0, 8'hFF, 64'h4001_3001_2001_1001, 1'b0);
        check_wr("wr", 1, 8'h00, 64'h4002_3002_2002_1002, 1'b1);

        // Reset mid-job
        wr_q.delete();
        start_job(8'h30, 8'd4);
        drive(4'hF, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);
        for (int i = 0; i < 5; i++) drive(4'b0001, 16'hDEAD, 0, 0, 0);
        drive(4'h0, 0, 0, 0, 0);
        check("mr_one_write", wr_q.size(), 1);
        check("mr_err_before", err, 2'b01);
        snap = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_wr_en", ub_wr_en, 0);
        check("mr_wr_addr", ub_wr_addr, 0);
        check("mr_wr_data", ub_wr_data, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_err", err, 0);
        tick();
        check("mr_no_done", done_cnt, snap);
        wr_q.delete();
        start_job(8'h60, 8'd1);
        drive(4'hF, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
        drive(4'h0, 0, 0, 0, 0);
        wait_done("mr", snap);
        check("mr_count", wr_q.size(), 1);
        check_wr("mr", 0, 8'h60, 64'h0044_0033_0022_0011, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
